// File: rtl/axis_word_to_byte_if.sv
// Bundle of the 32-bit slave stream, the 8-bit master stream and the packet
// status outputs of axis_word_to_byte.
interface axis_word_to_byte_if;
  logic        i_tready;
  logic        i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic        o_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_pkt_done;
  logic [31:0] o_pkt_len;
  logic        o_empty_pkt;

  // Serialiser side.
  modport slave (
    output i_tready, o_tvalid, o_tdata, o_tlast, o_pkt_done, o_pkt_len, o_empty_pkt,
    input  i_tvalid, i_tdata, i_tkeep, i_tlast, o_tready
  );

  // Word producer / byte consumer side.
  modport master (
    input  i_tready, o_tvalid, o_tdata, o_tlast, o_pkt_done, o_pkt_len, o_empty_pkt,
    output i_tvalid, i_tdata, i_tkeep, i_tlast, o_tready
  );
endinterface

// File: rtl/axis_word_to_byte.sv
// 32-bit keep/last AXI-stream to 8-bit AXI-stream serialiser with per-packet
// byte count. A one-byte hold stage lets a trailing keep-0 tlast word retag it.
module axis_word_to_byte (
  input  logic        clk,
  input  logic        rst,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [31:0] i_tdata,
  input  logic [3:0]  i_tkeep,
  input  logic        i_tlast,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  output logic        o_pkt_done,
  output logic [31:0] o_pkt_len,
  output logic        o_empty_pkt
);

  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  rem_q, rem_d;
  logic        lastp_q, lastp_d;
  logic        hvalid_q, hvalid_d;
  logic [7:0]  hdata_q, hdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic        done_q, done_d;
  logic        empty_q, empty_d;

  logic        in_hs, out_hs;
  logic [31:0] cnt_inc;
  logic [1:0]  lane;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) idx = 2'(k);
    return idx;
  endfunction

  assign i_tready    = (rem_q == 4'd0) & ~lastp_q;
  // Last byte of a word waits until we know whether it ends the packet.
  assign o_tvalid    = hvalid_q & ((rem_q != 4'd0) | lastp_q);
  assign o_tlast     = lastp_q & (rem_q == 4'd0);
  assign o_tdata     = hdata_q;
  assign o_pkt_done  = done_q;
  assign o_pkt_len   = len_q;
  assign o_empty_pkt = empty_q;

  assign in_hs   = i_tvalid & i_tready;
  assign out_hs  = o_tvalid & o_tready;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign lane    = low_lane(rem_q);

  always_comb begin
    wdata_d  = wdata_q;
    rem_d    = rem_q;
    lastp_d  = lastp_q;
    hvalid_d = hvalid_q;
    hdata_d  = hdata_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    done_d   = 1'b0;
    empty_d  = 1'b0;

    // i_tready implies rem_q == 0, so loading never collides with a refill.
    if (in_hs) begin
      wdata_d = i_tdata;
      rem_d   = i_tkeep;
      if (i_tlast) begin
        if ((i_tkeep != 4'd0) || hvalid_q) begin
          lastp_d = 1'b1;
        end else begin
          empty_d = 1'b1;
          cnt_d   = 32'd0;
        end
      end
    end

    if (out_hs) begin
      hvalid_d = 1'b0;
      cnt_d    = cnt_inc;
      if (o_tlast) begin
        len_d   = cnt_inc;
        cnt_d   = 32'd0;
        lastp_d = 1'b0;
        done_d  = 1'b1;
      end
    end

    if ((~hvalid_q | out_hs) && (rem_q != 4'd0)) begin
      hdata_d  = wdata_q[{lane, 3'b000} +: 8];
      rem_d    = rem_q & (rem_q - 4'd1);
      hvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_q  <= '0;
      rem_q    <= '0;
      lastp_q  <= 1'b0;
      hvalid_q <= 1'b0;
      hdata_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      wdata_q  <= wdata_d;
      rem_q    <= rem_d;
      lastp_q  <= lastp_d;
      hvalid_q <= hvalid_d;
      hdata_q  <= hdata_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: tb/tb_axis_word_to_byte.sv
// Directed bench for axis_word_to_byte: byte order, tlast placement, counts,
// empty packets, backpressure stability and mid-packet reset.
module tb_axis_word_to_byte;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_word_to_byte_if bus();

  axis_word_to_byte dut (
    .clk        (clk),
    .rst        (rst),
    .i_tready   (bus.i_tready),
    .i_tvalid   (bus.i_tvalid),
    .i_tdata    (bus.i_tdata),
    .i_tkeep    (bus.i_tkeep),
    .i_tlast    (bus.i_tlast),
    .o_tready   (bus.o_tready),
    .o_tvalid   (bus.o_tvalid),
    .o_tdata    (bus.o_tdata),
    .o_tlast    (bus.o_tlast),
    .o_pkt_done (bus.o_pkt_done),
    .o_pkt_len  (bus.o_pkt_len),
    .o_empty_pkt(bus.o_empty_pkt)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int empty_cnt = 0;
  int stall_viol = 0;
  bit bp = 1'b0;
  logic [8:0] got[$];
  bit stalled = 1'b0;
  logic [7:0] st_data;
  logic st_last;

  // Byte sink: drives o_tready, records handshaken {tlast,tdata}, counts pulses.
  always @(negedge clk) begin
    bus.o_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (!rst) begin
      if (stalled && (!bus.o_tvalid || bus.o_tdata !== st_data || bus.o_tlast !== st_last))
        stall_viol++;
      if (bus.o_tvalid && bus.o_tready) got.push_back({bus.o_tlast, bus.o_tdata});
      stalled = bus.o_tvalid && !bus.o_tready;
      st_data = bus.o_tdata;
      st_last = bus.o_tlast;
      done_cnt += int'(bus.o_pkt_done);
      empty_cnt += int'(bus.o_empty_pkt);
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    bus.i_tvalid = 1'b1;
    bus.i_tdata  = d;
    bus.i_tkeep  = k;
    bus.i_tlast  = l;
    while (!bus.i_tready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_tready) begin
      checks++; errors++;
      $display("FAIL send_word timeout: i_tready=%0b required 1", bus.i_tready);
    end
    @(negedge clk);
    bus.i_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int start, input string name);
    int n = 0;
    while (done_cnt == start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      errors++;
      $display("FAIL %s done_timeout: done pulses=%0d required >%0d", name, done_cnt, start);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_bytes(input string name, input logic [8:0] exp[$]);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d required %0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s byte%0d: got last=%0b data=%02h required last=%0b data=%02h",
                   name, i, got[i][8], got[i][7:0], exp[i][8], exp[i][7:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.i_tready !== 1'b1 || bus.o_tvalid !== 1'b0 || bus.o_tdata !== 8'h00 ||
        bus.o_tlast !== 1'b0 || bus.o_pkt_done !== 1'b0 || bus.o_pkt_len !== 32'd0 ||
        bus.o_empty_pkt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b data=%02h last=%0b done=%0b len=%0d empty=%0b required 1 0 00 0 0 0 0",
               bus.i_tready, bus.o_tvalid, bus.o_tdata, bus.o_tlast, bus.o_pkt_done,
               bus.o_pkt_len, bus.o_empty_pkt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_words();
    int d0 = done_cnt;
    got.delete();
    send_word(32'h44332211, 4'b1111, 1'b0);
    send_word(32'h00006655, 4'b0011, 1'b1);
    wait_done(d0, "two_words");
    check_bytes("two_words", '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h166});
    checks++;
    if (bus.o_pkt_len !== 32'd6 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL two_words len: got len=%0d pulses=%0d required len=6 pulses=1",
               bus.o_pkt_len, done_cnt - d0);
    end
  endtask

  task automatic test_zero_keep_last();
    int d0 = done_cnt;
    got.delete();
    send_word(32'hDDCCBBAA, 4'b1111, 1'b0);
    send_word(32'h00000000, 4'b0000, 1'b1);
    wait_done(d0, "zero_keep_last");
    check_bytes("zero_keep_last", '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD});
    checks++;
    if (bus.o_pkt_len !== 32'd4) begin
      errors++;
      $display("FAIL zero_keep_last len: got %0d required 4", bus.o_pkt_len);
    end
  endtask

  task automatic test_empty_packet();
    int d0 = done_cnt;
    int e0 = empty_cnt;
    got.delete();
    send_word(32'h12345678, 4'b0000, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (empty_cnt !== e0 + 1 || done_cnt !== d0 || got.size() != 0 || bus.o_pkt_len !== 32'd4) begin
      errors++;
      $display("FAIL empty_packet: empty=%0d done=%0d bytes=%0d len=%0d required 1 0 0 4",
               empty_cnt - e0, done_cnt - d0, got.size(), bus.o_pkt_len);
    end
  endtask

  task automatic test_sparse_keep();
    int d0 = done_cnt;
    got.delete();
    send_word(32'h44332211, 4'b1010, 1'b1);
    wait_done(d0, "sparse_keep");
    check_bytes("sparse_keep", '{9'h022, 9'h144});
    checks++;
    if (bus.o_pkt_len !== 32'd2) begin
      errors++;
      $display("FAIL sparse_keep len: got %0d required 2", bus.o_pkt_len);
    end
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    int bad = 0;
    logic [31:0] w;
    logic [8:0] e;
    got.delete();
    stall_viol = 0;
    bp = 1'b1;
    for (int i = 0; i < 250; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_word(w, 4'b1111, i == 249);
    end
    wait_done(d0, "backpressure");
    bp = 1'b0;
    checks++;
    if (got.size() != 1000) begin
      errors++;
      $display("FAIL backpressure byte_count: got %0d required 1000", got.size());
    end else begin
      for (int n = 0; n < 1000; n++) begin
        e = {n == 999, 8'(n)};
        if (got[n] !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL backpressure data: %0d wrong bytes required 0", bad);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL backpressure stability: %0d changes while stalled required 0", stall_viol);
    end
    checks++;
    if (bus.o_pkt_len !== 32'd1000) begin
      errors++;
      $display("FAIL backpressure len: got %0d required 1000", bus.o_pkt_len);
    end
  endtask

  task automatic test_reset_mid_packet();
    int d0;
    int n = 0;
    got.delete();
    send_word(32'h03020100, 4'b1111, 1'b0);
    while (got.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL reset_mid bytes_before: got %0d required 3", got.size());
    end
    d0 = done_cnt;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_tvalid !== 1'b0 || bus.i_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid async: vld=%0b rdy=%0b required 0 1", bus.o_tvalid, bus.i_tready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL reset_mid no_done: got %0d pulses required 0", done_cnt - d0);
    end
    got.delete();
    send_word(32'h00CCBBAA, 4'b0111, 1'b1);
    wait_done(d0, "reset_mid_next");
    check_bytes("reset_mid_next", '{9'h0AA, 9'h0BB, 9'h1CC});
    checks++;
    if (bus.o_pkt_len !== 32'd3) begin
      errors++;
      $display("FAIL reset_mid_next len: got %0d required 3", bus.o_pkt_len);
    end
  endtask

  initial begin
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tkeep  = '0;
    bus.i_tlast  = 1'b0;
    bus.o_tready = 1'b1;
    test_reset();
    test_two_words();
    test_zero_keep_last();
    test_empty_packet();
    test_sparse_keep();
    test_backpressure();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_word_to_byte.md
# axis_word_to_byte

Serialises a 32-bit AXI-stream with byte-lane keep and packet last into an 8-bit AXI-stream, one byte per beat, with `o_tlast` on the final byte of each packet. It sits directly downstream of the length-driven word generator in the 8-bit (FT232H-class) transmit path, feeding the byte-wide USB FIFO stage. It must absorb trailing all-zero-keep words carrying only `tlast` by moving the `tlast` onto the previously emitted byte. It also reports per-packet byte counts.

## Interface
Parameters: none; widths are fixed at 32 bits in and 8 bits out.

Ports:
- `clk`  in  1  Single clock for all logic.
- `rst`  in  1  Asynchronous reset, active-high.
- `i_tready`  out  1  Slave ready.
- `i_tvalid`  in  1  Slave valid.
- `i_tdata`  in  32  Slave data; lane k = bits [8k+7:8k].
- `i_tkeep`  in  4  Lane valid mask. May be non-contiguous or 0.
- `i_tlast`  in  1  Word ends the packet.
- `o_tready`  in  1  Master ready.
- `o_tvalid`  out  1  Master valid.
- `o_tdata`  out  8  Master byte.
- `o_tlast`  out  1  Final byte of the packet.
- `o_pkt_done`  out  1  One-cycle pulse in the cycle after the `o_tlast` byte handshakes.
- `o_pkt_len`  out  32  Byte count of the last completed packet. Valid from the `o_pkt_done` cycle and held until the next one.
- `o_empty_pkt`  out  1  One-cycle pulse when a packet containing zero bytes completes.

## Operation
Registers:
- Word buffer: `wdata`, remaining-lane mask `rem[3:0]`.
- `lastp`: packet end pending.
- Hold register: `hvalid`, `hdata`.
- Byte counter `cnt[31:0]`.

Rules:
- `i_tready = (rem == 0) & ~lastp`.
- On input handshake, load `wdata = i_tdata` and `rem = i_tkeep`.
  - If `i_tlast` and (`i_tkeep != 0` or `hvalid`): set `lastp`.
  - If `i_tlast`, `i_tkeep == 0`, `~hvalid`: this is an empty packet. Pulse `o_empty_pkt` next cycle, clear `cnt`, and do not set `lastp`.
  - If `i_tkeep == 0` and `~i_tlast`: the word is consumed and discarded.
- Hold refill: when (`~hvalid` or output handshake) and `rem != 0`:
  - move the lowest set lane of `rem` into `hdata`;
  - clear that bit;
  - set `hvalid`.
- Lane order: ascending lane index; lanes with keep 0 are skipped.
- `o_tvalid = hvalid & ((rem != 0) | lastp)`. The byte is withheld until it is known whether another byte follows, or that the packet has ended.
- `o_tlast = lastp & (rem == 0)`.
- On output handshake: `cnt <= cnt + 1`, saturating at 32'hFFFF_FFFF.
  - If `o_tlast`: `o_pkt_len <= cnt + 1` (saturated), `cnt <= 0`, clear `lastp`, pulse `o_pkt_done` next cycle.
- The hold register empties on handshake unless it is refilled in the same cycle.

## Timing
- Reset values: `i_tready=1`, `o_tvalid=0`, `o_tdata=0`, `o_tlast=0`, `o_pkt_done=0`, `o_pkt_len=0`, `o_empty_pkt=0`, all internal registers 0.
- Latency: first byte of a word is in hold one cycle after the word handshake. `o_tvalid` asserts that cycle if more lanes remain or `lastp` is set.
- Throughput: a full-keep word yields 4 bytes in 5 cycles. The bubble is caused by the lookahead on the word boundary; this is accepted.
- `o_tvalid` stays high, with `o_tdata`/`o_tlast` stable, until `o_tready`. AXI-stream rules apply; there are no combinational input-to-output paths.
- Simultaneous output handshake and input handshake in one cycle is legal. The refill uses the pre-edge `rem`.
- Keep-0 `tlast` word arriving while `hvalid` holds the packet's final byte: set `lastp`; that byte leaves with `o_tlast=1`.
- Reset mid-packet: all state cleared asynchronously. The partial packet is discarded, and no `o_pkt_done` or `o_empty_pkt` pulse is produced.

## Structure
- Single flat module with no sub-module.
- Lowest-set-lane selection is a local function (priority encode plus mask clear).
- No shared package entries; widths are fixed and all constants are local.

## Test plan
- Words 0x44332211/keep 1111/last 0 and 0x00006655/keep 0011/last 1 -> bytes 11,22,33,44,55,66 with `o_tlast` only on 66. Then `o_pkt_done` pulse with `o_pkt_len`=6.
- Word 0xDDCCBBAA/keep 1111/last 0, then 0x0/keep 0000/last 1 -> AA..DD with `o_tlast` on DD, `o_pkt_len`=4.
- Single word keep 0000/last 1 with the block idle -> no output bytes, one `o_empty_pkt` pulse, `o_pkt_len` unchanged.
- Keep 1010 on 0x44332211, last 1 -> bytes 22,44, `o_tlast` on 44, `o_pkt_len`=2.
- Random `o_tready` backpressure (about 50%) on a 1000-byte packet -> byte n = n mod 256 in order, `o_tdata` stable while stalled, `o_pkt_len`=1000.
- Assert `rst` after 3 bytes of a 10-byte packet -> `o_tvalid`=0 immediately, `i_tready`=1, no done pulse. The next packet is counted from 0.
